// File: rtl/lsu.sv
// Load/store unit for the multi-cycle RV32I core. Validates the access,
// runs a single valid/ready request to the data bus, and turns loads into
// extended register values and stores into byte-strobed word writes.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_result,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    // Value of the wait counter on the last REQ cycle still allowed to see ready.
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [1:0]  byte_off;
    logic [2:0]  width_q;

    logic        funct3_ok;
    logic        aligned;
    logic        req_ok;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    // Decode the incoming request: legality, alignment and store lane layout.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        funct3_ok  = 1'b0;
        aligned    = 1'b0;
        lane_wdata = store_data;
        lane_wstrb = 4'b0000;

        if (is_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok = 1'b1;
                default:                                funct3_ok = 1'b0;
            endcase
        end else if (is_store) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
                default:                funct3_ok = 1'b0;
            endcase
        end

        // funct3[1:0] encodes the access size for both loads and stores.
        case (funct3[1:0])
            2'b00: begin
                aligned    = 1'b1;
                lane_wdata = {4{store_data[7:0]}};
                lane_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                aligned    = ~addr[0];
                lane_wdata = {2{store_data[15:0]}};
                lane_wstrb = 4'b0011 << addr[1:0];
            end
            2'b10: begin
                aligned    = (addr[1:0] == 2'b00);
                lane_wdata = store_data;
                lane_wstrb = 4'b1111;
            end
            default: begin
                aligned    = 1'b0;
                lane_wdata = store_data;
                lane_wstrb = 4'b0000;
            end
        endcase

        req_ok = (is_load ^ is_store) && funct3_ok && aligned;
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    always_comb begin
        rd_byte = mem_rdata[7:0];
        rd_half = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        rd_ext  = mem_rdata;

        case (byte_off)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase

        case (width_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    // Access sequencer: IDLE -> REQ -> DONE, or IDLE -> DONE on a rejected request.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            load_result <= 32'd0;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_wstrb   <= 4'b0000;
            wait_cnt    <= 16'd0;
            byte_off    <= 2'd0;
            width_q     <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (req_ok) begin
                            state     <= REQ;
                            mem_valid <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= lane_wdata;
                            mem_wstrb <= is_store ? lane_wstrb : 4'b0000;
                            byte_off  <= addr[1:0];
                            width_q   <= funct3;
                            wait_cnt  <= 16'd0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            load_result <= rd_ext;
                        end
                        mem_valid <= 1'b0;
                        state     <= DONE;
                        done      <= 1'b1;
                        err       <= 1'b0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem_valid <= 1'b0;
                        state     <= DONE;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed test-plan vectors plus randomized accesses, all
// checked cycle by cycle against a transaction-level model of the unit.
module tb_lsu;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] load_result;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    lsu #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .load_result(load_result),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected values for the current cycle, set by the stimulus thread.
    logic        chk_en = 1'b0;
    logic        chk_bus = 1'b0;
    logic        chk_wdata = 1'b0;
    logic        exp_busy, exp_done, exp_err, exp_valid, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_result;
    logic [3:0]  exp_wstrb;

    // Observations of the DUT bus, used for literal test-plan checks.
    int          vcnt = 0;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_wstrb;
    logic        seen_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_reject(input logic ld, input logic st,
                                        input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int n;
        if (ld == st) return 1'b1;
        if (ld) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        else    legal = (f3 <= 3'd2);
        if (!legal) return 1'b1;
        n = size_bytes(f3);
        return (a % n) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * off);
        case (f3)
            3'b000:  return 32'($signed(sh[7:0]));
            3'b001:  return 32'($signed(sh[15:0]));
            3'b100:  return 32'(sh[7:0]);
            3'b101:  return 32'(sh[15:0]);
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] off);
        int n;
        n = size_bytes(f3);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        int n;
        n = size_bytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    // ---------------- per-cycle compare ----------------
    task automatic compare_all();
        vcnt += int'(mem_valid);
        if (mem_valid) begin
            seen_addr  = mem_addr;
            seen_wdata = mem_wdata;
            seen_wstrb = mem_wstrb;
            seen_we    = mem_we;
        end
        if (chk_en) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("err", 32'(err), 32'(exp_err));
            check("mem_valid", 32'(mem_valid), 32'(exp_valid));
            check("load_result", load_result, exp_result);
            if (chk_bus) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", 32'(mem_we), 32'(exp_we));
                check("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                if (chk_wdata) check("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    endtask

    // One clock: compare on the falling edge, then step to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_phase(input logic b, input logic d, input logic e, input logic v);
        exp_busy  = b;
        exp_done  = d;
        exp_err   = e;
        exp_valid = v;
        chk_bus   = v;
    endtask

    task automatic scramble_inputs();
        is_load    = 1'($urandom);
        is_store   = 1'($urandom);
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
    endtask

    // A legal word load that would certainly be accepted if start were sampled.
    task automatic poke_start();
        start    = 1'b1;
        is_load  = 1'b1;
        is_store = 1'b0;
        funct3   = 3'b010;
        addr     = $urandom & 32'hFFFF_FFFC;
    endtask

    // Issue one access beginning in an IDLE cycle; the memory answers in REQ cycle wait_n.
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rd, input int wait_n, input bit poke);
        bit reject, ok;
        int k;
        reject = model_reject(ld, st, f3, a);

        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
        mem_ready = 1'b0; mem_rdata = $urandom;
        expect_phase(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        scramble_inputs();

        if (reject) begin
            expect_phase(1'b1, 1'b1, 1'b1, 1'b0);
            if (poke) poke_start();
            tick();
            start = 1'b0;
            return;
        end

        exp_addr  = {a[31:2], 2'b00};
        exp_we    = st;
        exp_wstrb = st ? model_strb(f3, a[1:0]) : 4'b0000;
        exp_wdata = model_wdata(f3, sd);
        chk_wdata = st;
        ok = 1'b0;
        k  = 0;
        while (1) begin
            expect_phase(1'b1, 1'b0, 1'b0, 1'b1);
            mem_ready = (k == wait_n);
            mem_rdata = mem_ready ? rd : $urandom;
            if (poke && k == 0) poke_start();
            tick();
            start = 1'b0;
            if (k == wait_n) begin ok = 1'b1; break; end
            if (k == int'(TMO) - 1) break;
            k++;
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        expect_phase(1'b1, 1'b1, !ok, 1'b0);
        if (ld && ok) exp_result = model_load(f3, a[1:0], rd);
        if (poke) poke_start();
        tick();
        start = 1'b0;
    endtask

    int base;

    initial begin
        rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = 32'd0; store_data = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;

        // Reset state: everything zero while rst is held.
        @(posedge clk); #1;
        chk_en = 1'b1; chk_wdata = 1'b1;
        exp_result = 32'd0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_wstrb = 4'd0; exp_we = 1'b0;
        expect_phase(1'b0, 1'b0, 1'b0, 1'b0);
        chk_bus = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Word load, zero-wait.
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'h8765_4321, 0, 0);
        check("lw_result_lit", load_result, 32'h8765_4321);
        check("lw_addr_lit", seen_addr, 32'h100);
        check("lw_wstrb_lit", 32'(seen_wstrb), 32'h0);

        // Extension cases, back to back.
        run_access(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF_7F01, 0, 1);
        check("lb_lit", load_result, 32'hFFFF_FF80);
        run_access(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF_7F01, 1, 0);
        check("lbu_lit", load_result, 32'h0000_0080);
        run_access(1, 0, 3'b001, 32'h202, 32'h0, 32'h80FF_7F01, 0, 0);
        check("lh_lit", load_result, 32'hFFFF_80FF);
        run_access(1, 0, 3'b101, 32'h200, 32'h0, 32'h80FF_7F01, 2, 1);
        check("lhu_lit", load_result, 32'h0000_7F01);

        // Store lanes.
        run_access(0, 1, 3'b000, 32'h1, 32'hDEAD_BEEF, 32'h0, 0, 0);
        check("sb_wdata_lit", seen_wdata, 32'hEFEF_EFEF);
        check("sb_wstrb_lit", 32'(seen_wstrb), 32'b0010);
        run_access(0, 1, 3'b001, 32'h2, 32'hDEAD_BEEF, 32'h0, 1, 0);
        check("sh_wdata_lit", seen_wdata, 32'hBEEF_BEEF);
        check("sh_wstrb_lit", 32'(seen_wstrb), 32'b1100);
        run_access(0, 1, 3'b010, 32'h4, 32'hDEAD_BEEF, 32'h0, 0, 1);
        check("sw_wstrb_lit", 32'(seen_wstrb), 32'b1111);
        check("sw_we_lit", 32'(seen_we), 32'h1);
        check("lhu_held_lit", load_result, 32'h0000_7F01);

        // Rejected accesses: no bus request at all.
        base = vcnt;
        run_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1);
        run_access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
        run_access(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 1);
        check("reject_no_valid", 32'(vcnt - base), 32'd0);

        // Wait states: ready on the final allowed cycle, then no ready at all.
        run_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h1234_5678, int'(TMO) - 1, 0);
        check("last_cycle_ok_lit", load_result, 32'h1234_5678);
        base = vcnt;
        run_access(1, 0, 3'b010, 32'h304, 32'h0, 32'hAAAA_5555, 1000, 0);
        check("timeout_valid_cycles", 32'(vcnt - base), 32'(TMO));
        check("timeout_result_held", load_result, 32'h1234_5678);

        // Reset in the middle of REQ, with an ignored start while busy.
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        expect_phase(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        exp_addr = 32'h40; exp_we = 1'b0; exp_wstrb = 4'd0; chk_wdata = 1'b0;
        expect_phase(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        poke_start();
        tick();
        start = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_result = 32'd0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_wstrb = 4'd0; chk_wdata = 1'b1;
        expect_phase(1'b0, 1'b0, 1'b0, 1'b0);
        chk_bus = 1'b1;
        tick();
        chk_bus = 1'b0;
        tick();
        tick();

        // Randomized accesses.
        for (int t = 0; t < 300; t++) begin
            logic ld, st;
            logic [2:0] f3;
            logic [31:0] a;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      begin ld = 1'b1; st = 1'b1; end
            else if (sel == 1) begin ld = 1'b0; st = 1'b0; end
            else               begin ld = 1'($urandom); st = !ld; end
            f3 = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 9) < 7) a = a & ~32'(size_bytes(f3) - 1);
            run_access(ld, st, f3, a, $urandom, $urandom,
                       int'($urandom_range(0, 5)), 1'($urandom));
        end

        expect_phase(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
